// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with its own IDLE/CALC/SIGN/DONE sequencer.
module muldiv_sequencer #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [Width-1:0] rs1,
  input  logic [Width-1:0] rs2,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             valid,
  output logic [Width-1:0] result
);

  localparam int CW = $clog2(Width) + 1;
  localparam logic [CW-1:0]    LastIter = CW'(Width - 1);
  localparam logic [Width-1:0] MinNeg   = {1'b1, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic [Width:0]     acc;
  logic [Width-1:0]   lo;
  logic [Width-1:0]   opnd;
  logic               neg;
  logic [2:0]         op;

  function automatic logic [Width-1:0] magnitude(input logic signed [Width-1:0] x,
                                                 input logic is_signed);
    logic [Width-1:0] m;
    if (is_signed && x < 0) m = -x;
    else                    m = x;
    return m;
  endfunction

  // Negate the unsigned core result when required and pick the half the op asks for.
  function automatic logic [Width-1:0] fix_sign(input logic [2:0] f, input logic n,
                                                input logic [Width-1:0] hi,
                                                input logic [Width-1:0] low);
    logic [2*Width-1:0] prod;
    logic [Width-1:0]   res;
    prod = {hi, low};
    if (n) prod = -prod;
    case (f)
      3'b000:                 res = prod[Width-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*Width-1:Width];
      3'b100, 3'b101:         res = n ? -low : low;
      default:                res = n ? -hi : hi;
    endcase
    return res;
  endfunction

  function automatic logic [Width-1:0] special_result(input logic [2:0] f, input logic dz,
                                                      input logic [Width-1:0] a);
    logic [Width-1:0] res;
    if (dz) res = f[1] ? a : '1;
    else    res = f[1] ? '0 : a;
    return res;
  endfunction

  logic             accept, div_op, signed_a, signed_b, div_zero, div_ovf, special, neg_res;
  logic [Width-1:0] mag_a, mag_b;
  logic [Width:0]   mul_sum, div_shift, div_diff;

  assign accept   = (state == IDLE) && start && !flush;
  assign div_op   = funct3[2];
  assign signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (div_op && !funct3[0]);
  assign signed_b = (funct3 == 3'b001) || (div_op && !funct3[0]);
  assign mag_a    = magnitude(rs1, signed_a);
  assign mag_b    = magnitude(rs2, signed_b);
  assign neg_res  = (div_op && funct3[1]) ? (signed_a && rs1[Width-1])
                  : ((signed_a && rs1[Width-1]) ^ (signed_b && rs2[Width-1]));
  assign div_zero = div_op && (rs2 == '0);
  assign div_ovf  = div_op && !funct3[0] && (rs1 == MinNeg) && (rs2 == '1);
  assign special  = div_zero || div_ovf;

  // Multiply: {acc, lo} is the product register, lo shifts the multiplier out LSB first.
  // Divide: acc is the partial remainder, lo shifts the dividend in and the quotient out.
  assign mul_sum   = {1'b0, acc[Width-1:0]} + (lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc[Width-1:0], lo[Width-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = special ? DONE : CALC;
        CALC: if (count == LastIter) state_nxt = SIGN;
        SIGN: state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign stall = ((state == IDLE) && start) || (state == CALC) || (state == SIGN);
  assign busy  = (state == CALC) || (state == SIGN);
  assign valid = (state == DONE) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      neg    <= 1'b0;
      op     <= 3'b000;
      result <= '0;
    end else if (accept) begin
      count <= '0;
      acc   <= '0;
      op    <= funct3;
      neg   <= neg_res;
      lo    <= div_op ? mag_a : mag_b;
      opnd  <= div_op ? mag_b : mag_a;
      if (special) result <= special_result(funct3, div_zero, rs1);
    end else if (state == CALC && !flush) begin
      count <= count + CW'(1);
      if (op[2]) begin
        if (!div_diff[Width]) begin
          acc <= div_diff;
          lo  <= {lo[Width-2:0], 1'b1};
        end else begin
          acc <= div_shift;
          lo  <= {lo[Width-2:0], 1'b0};
        end
      end else begin
        acc <= {1'b0, mul_sum[Width:1]};
        lo  <= {mul_sum[0], lo[Width-1:1]};
      end
    end else if (state == SIGN && !flush) begin
      result <= fix_sign(op, neg, acc[Width-1:0], lo);
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a 64-bit arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        stall, busy, valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_exp = '0;

  localparam logic [31:0] MIN = 32'h8000_0000;

  muldiv_sequencer #(.Width(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ps;
    longint unsigned ua, ub, pu;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin pu = ua * ub; r = pu[31:0]; end
      3'd1: begin ps = sa * sb; r = ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); r = ps[63:32]; end
      3'd3: begin pu = ua * ub; r = pu[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == MIN && b == 32'hFFFF_FFFF) r = a;
        else begin ps = sa / sb; r = ps[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin pu = ua / ub; r = pu[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MIN && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin ps = sa % sb; r = ps[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin pu = ua % ub; r = pu[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = MIN;
      3: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Launches one op in cycle 0 and watches up to 100 cycles for valid.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int st,
                       output int bz, output logic stall_at_valid);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    #1;
    lat = 0; res = 'x; stall_at_valid = 1'bx;
    st = int'(stall);
    bz = int'(busy);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (valid) begin
        lat = c; res = result; stall_at_valid = stall;
        break;
      end
      st += int'(stall);
      bz += int'(busy);
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] res, exp;
    int lat, st, bz, el;
    logic sv;
    exp = ref_model(f, a, b);
    el  = exp_latency(f, a, b);
    do_op(f, a, b, res, lat, st, bz, sv);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s result f=%0d a=%h b=%h: got %h expected %h", name, f, a, b, res, exp);
    end
    checks++;
    if (lat != el) begin
      errors++;
      $display("FAIL %s latency f=%0d a=%h b=%h: got %0d expected %0d", name, f, a, b, lat, el);
    end
    checks++;
    if (st != el || sv !== 1'b0) begin
      errors++;
      $display("FAIL %s stall cycles: got %0d (at valid %b) expected %0d (at valid 0)",
               name, st, sv, el);
    end
    checks++;
    if (bz != el - 1) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, bz, el - 1);
    end
    last_exp = exp;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({stall, busy, valid} !== 3'b000 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got stall=%b busy=%b valid=%b result=%h expected all 0",
               stall, busy, valid, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({stall, busy, valid} !== 3'b000 || result !== 32'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got stall=%b busy=%b valid=%b result=%h expected all 0",
               stall, busy, valid, result);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  f [10] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd7, 3'd2};
    logic [31:0] a [10] = '{32'd7, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'd5, MIN, MIN, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] b [10] = '{32'hFFFF_FFFD, MIN, 32'hFFFF_FFFF, 32'd2, 32'd2,
                            32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] e [10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MIN, 32'h1234_5678,
                            32'hFFFF_FFFF};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ref_model(f[i], a[i], b[i]) !== e[i]) begin
        errors++;
        $display("FAIL model_vector_%0d: got %h expected %h", i, ref_model(f[i], a[i], b[i]), e[i]);
      end
      check_op($sformatf("directed_%0d", i), f[i], a[i], b[i]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_op($sformatf("random_%0d", i), 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
  endtask

  task automatic test_flush();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    funct3 = 3'd4; rs1 = $urandom; rs2 = 32'd3; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      if (valid) seen = 1'b1;
      if (c == 10) flush = 1'b1;
    end
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || seen) begin
      errors++;
      $display("FAIL flush_to_idle: got busy=%b stall=%b valid_seen=%b expected 0 0 0",
               busy, stall, seen);
    end
    checks++;
    if (result !== last_exp) begin
      errors++;
      $display("FAIL flush_result_hold: got %h expected %h", result, last_exp);
    end
    check_op("after_flush", 3'd4, 32'hFFFF_FFF9, 32'd2);
    // flush together with start in IDLE must not accept
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (valid || busy) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen || result !== last_exp) begin
      errors++;
      $display("FAIL flush_with_start: got activity=%b result=%h expected 0 and %h",
               seen, result, last_exp);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_mul: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, busy, valid} !== 3'b000 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_op: got stall=%b busy=%b valid=%b result=%h expected all 0",
               stall, busy, valid, result);
    end
    last_exp = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (valid || busy) break;
    end
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_valid_after_reset: got valid=%b busy=%b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] a, b, exp, res;
    int lat, bz;
    logic seen;
    a = $urandom; b = $urandom;
    exp = ref_model(3'd1, a, b);
    lat = 0; bz = 0; res = 'x;
    @(negedge clk);
    funct3 = 3'd1; rs1 = a; rs2 = b; start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (valid) begin
        lat = c; res = result;
        start = 1'b1;
        rs1 = $urandom; rs2 = $urandom;
        break;
      end
      bz += int'(busy);
      if (c >= 3 && c <= 6) begin
        start = 1'b1; rs1 = $urandom; rs2 = 32'd0; funct3 = 3'd5;
      end
    end
    checks++;
    if (lat != 34 || res !== exp || bz != 33) begin
      errors++;
      $display("FAIL start_during_calc: got lat=%0d result=%h busy=%0d expected 34 %h 33",
               lat, res, bz, exp);
    end
    last_exp = exp;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (valid || busy || stall) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen || result !== last_exp) begin
      errors++;
      $display("FAIL start_in_done_ignored: got activity=%b result=%h expected 0 and %h",
               seen, result, last_exp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_start_ignored();
    check_op("final_back_to_back", 3'd7, $urandom, 32'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
